data_mem_unit: RTL

//  Data-side memory controller for the RV32 core: byte-enabled sub-word stores, sign/zero-extended loads, misalignment

---
 rtl/data_mem_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/data_mem_unit.sv
// data_mem_unit: RV32 data-side memory controller with byte-lane RAM, sign/zero-extended loads, and 7-seg/UART MMIO with stall flow control
module data_mem_unit #(
  parameter int          ADDR_W    = 15,
  parameter logic [31:0] SEG_ADDR  = 32'h0,
  parameter logic [31:0] UART_ADDR = 32'h4,
  parameter int          SEG_W     = 16,
  parameter bit          BLOCKING  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      writedata_i,
  input  logic             writectrl_i,
  input  logic             readctrl_i,
  output logic [31:0]      readdata_o,
  output logic             stall_o,
  output logic             misalign_o,
  input  logic             uart_empty_i,
  input  logic [7:0]       uart_in_i,
  output logic             rdreq_o,
  input  logic             uart_full_i,
  output logic [7:0]       uart_out_o,
  output logic             wrreq_o,
  output logic [SEG_W-1:0] seg_io_o
);
  localparam logic [1:0] IDLE = 2'd0, RXW = 2'd1, TXW = 2'd2;
  logic [1:0] state_q, state_d;
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] ram_q, rdat_q, wd;
  logic [3:0] be;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic ram_sel_q, misalign_q;
  logic [SEG_W-1:0] seg_q;
  logic st, ld, is_seg, is_uart, aligned, idle, acc, bad, ul, us, rx_ok, tx_ok;
  logic ram_acc, ram_we, seg_we, nb_empty;
  logic [ADDR_W-1:0] idx;
  logic [7:0] lb;
  logic [15:0] lh;
  always_comb begin
    st       = writectrl_i;
    ld       = readctrl_i & ~writectrl_i;
    is_seg   = addr_i == SEG_ADDR;
    is_uart  = addr_i == UART_ADDR;
    aligned  = funct3_i[1:0] == 2'b01 ? ~addr_i[0] : funct3_i[1:0] == 2'b10 ? addr_i[1:0] == 2'b00 : 1'b1;
    idle     = state_q == IDLE;
    acc      = idle & (st | ld);
    bad      = acc & ~aligned;
    ul       = ld & is_uart & aligned;
    us       = st & is_uart & aligned;
    rx_ok    = ul & (idle | state_q == RXW);
    tx_ok    = us & (idle | state_q == TXW);
    rdreq_o  = rst_n & rx_ok & ~uart_empty_i;
    wrreq_o  = rst_n & tx_ok & ~uart_full_i;
    stall_o  = rst_n & BLOCKING & ((rx_ok & uart_empty_i) | (tx_ok & uart_full_i));
    state_d  = ~stall_o ? IDLE : ul ? RXW : TXW;
    ram_acc  = acc & aligned & ~is_seg & ~is_uart;
    ram_we   = ram_acc & st;
    seg_we   = acc & aligned & is_seg & st;
    nb_empty = idle & ul & uart_empty_i & ~BLOCKING;
    idx      = addr_i[ADDR_W+1:2];
    be       = funct3_i[1:0] == 2'b00 ? 4'b0001 << addr_i[1:0] :
               funct3_i[1:0] == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd       = funct3_i[1:0] == 2'b00 ? {4{writedata_i[7:0]}} :
               funct3_i[1:0] == 2'b01 ? {2{writedata_i[15:0]}} : writedata_i;
    lb       = ram_q[{off_q, 3'b000} +: 8];
    lh       = off_q[1] ? ram_q[31:16] : ram_q[15:0];
    readdata_o = ~ram_sel_q       ? rdat_q :
                 f3_q == 3'b000   ? {{24{lb[7]}}, lb} :
                 f3_q == 3'b100   ? {24'b0, lb} :
                 f3_q == 3'b001   ? {{16{lh[15]}}, lh} :
                 f3_q == 3'b101   ? {16'b0, lh} : ram_q;
    misalign_o = misalign_q;
    uart_out_o = writedata_i[7:0];
    seg_io_o   = seg_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      misalign_q <= 1'b0;
      seg_q      <= '0;
      ram_sel_q  <= 1'b0;
      rdat_q     <= '0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      misalign_q <= bad;
      if (seg_we) seg_q <= writedata_i[SEG_W-1:0];
      if (bad) begin
        ram_sel_q <= 1'b0;
        rdat_q    <= '0;
      end else if (ram_acc & ld) begin
        ram_sel_q <= 1'b1;
        f3_q      <= funct3_i;
        off_q     <= addr_i[1:0];
      end else if (acc & ld & is_seg) begin
        ram_sel_q <= 1'b0;
        rdat_q    <= 32'(seg_q);
      end else if (rdreq_o) begin
        ram_sel_q <= 1'b0;
        rdat_q    <= {24'b0, uart_in_i};
      end else if (nb_empty) begin
        ram_sel_q <= 1'b0;
        rdat_q    <= '1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (ram_acc & ld) ram_q <= mem[idx];
    for (int b = 0; b < 4; b++)
      if (ram_we & be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
  end
endmodule
